// File: rtl/leaderboard_pkg.sv
// ---------------------------------------------------------------------------
// leaderboard_pkg
// Shared definitions for the leaderboard controller and its table slices:
// table-mode codes, display-select codes, the controller FSM state type,
// the default time width and a small rank-to-buzzer helper.
// No ports (package).
// ---------------------------------------------------------------------------
package leaderboard_pkg;

    localparam int TIME_W_DEFAULT = 22;

    // Table selection carried with each finished time
    localparam logic [1:0] MODE_SLOW = 2'b01;
    localparam logic [1:0] MODE_FAST = 2'b10;

    // Display-mux select codes; anything else reads as an empty slot
    localparam logic [2:0] DISP_FAST1 = 3'b001;
    localparam logic [2:0] DISP_FAST2 = 3'b010;
    localparam logic [2:0] DISP_FAST3 = 3'b011;
    localparam logic [2:0] DISP_SLOW1 = 3'b100;
    localparam logic [2:0] DISP_SLOW2 = 3'b101;
    localparam logic [2:0] DISP_SLOW3 = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMP   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } lb_state_t;

    // Buzzer line for a placement: rank 1 drives bit 0, rank 3 drives bit 2
    function automatic logic [2:0] rank_onehot(input logic [1:0] r);
        logic [2:0] oh;
        case (r)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/lb_table.sv
// ---------------------------------------------------------------------------
// lb_table
// Three-entry ranked time table with per-slot valid bits. Slot 0 is the best
// time. Provides a single-slot win compare for the ranking sequencer, a
// shift-insert at a given position and an asynchronous read port.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        empty the table (entries and valid bits)
//   i_insert       shift slots pos..1 down one, drop slot 2, write i_time at pos
//   i_pos          insert position 0..2
//   i_time         candidate time (compare and insert data)
//   i_less         1: smaller time wins (fast table), 0: larger wins (slow)
//   i_cmp_idx      slot being compared this cycle
//   o_win          candidate beats slot i_cmp_idx (empty slot always loses)
//   i_rd_idx       read slot
//   o_rd_time      entry at i_rd_idx (0 for out-of-range index)
//   o_rd_valid     valid bit at i_rd_idx
// ---------------------------------------------------------------------------
module lb_table #(
    parameter int TIME_W = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_insert,
    input  logic [1:0]        i_pos,
    input  logic [TIME_W-1:0] i_time,
    input  logic              i_less,
    input  logic [1:0]        i_cmp_idx,
    output logic              o_win,
    input  logic [1:0]        i_rd_idx,
    output logic [TIME_W-1:0] o_rd_time,
    output logic              o_rd_valid
);

    logic [TIME_W-1:0] r_entry [0:2];
    logic [2:0]        r_valid;

    logic [TIME_W-1:0] w_cmp_entry;
    logic              w_cmp_valid;

    // Pick the slot under comparison. An empty slot is always beaten, and a
    // tie never wins so the entry that arrived first keeps the better rank.
    always_comb begin
        w_cmp_entry = '0;
        w_cmp_valid = 1'b0;
        case (i_cmp_idx)
            2'd0: begin w_cmp_entry = r_entry[0]; w_cmp_valid = r_valid[0]; end
            2'd1: begin w_cmp_entry = r_entry[1]; w_cmp_valid = r_valid[1]; end
            2'd2: begin w_cmp_entry = r_entry[2]; w_cmp_valid = r_valid[2]; end
            default: begin w_cmp_entry = '0; w_cmp_valid = 1'b0; end
        endcase
        if (!w_cmp_valid) begin
            o_win = 1'b1;
        end else if (i_less) begin
            o_win = (i_time < w_cmp_entry);
        end else begin
            o_win = (i_time > w_cmp_entry);
        end
    end

    // Read mux for the display path; the controller registers the result.
    always_comb begin
        o_rd_time  = '0;
        o_rd_valid = 1'b0;
        case (i_rd_idx)
            2'd0: begin o_rd_time = r_entry[0]; o_rd_valid = r_valid[0]; end
            2'd1: begin o_rd_time = r_entry[1]; o_rd_valid = r_valid[1]; end
            2'd2: begin o_rd_time = r_entry[2]; o_rd_valid = r_valid[2]; end
            default: begin o_rd_time = '0; o_rd_valid = 1'b0; end
        endcase
    end

    // Table storage. Clear wipes everything; an insert pushes the entries
    // at and below the insert point down one slot so the old slot 2 falls off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_entry[i] <= '0;
            end
            r_valid <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < 3; i++) begin
                r_entry[i] <= '0;
            end
            r_valid <= '0;
        end else if (i_insert) begin
            case (i_pos)
                2'd0: begin
                    r_entry[2] <= r_entry[1];
                    r_entry[1] <= r_entry[0];
                    r_entry[0] <= i_time;
                    r_valid    <= {r_valid[1], r_valid[0], 1'b1};
                end
                2'd1: begin
                    r_entry[2] <= r_entry[1];
                    r_entry[1] <= i_time;
                    r_valid    <= {r_valid[1], 1'b1, r_valid[0]};
                end
                2'd2: begin
                    r_entry[2] <= i_time;
                    r_valid[2] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/leaderboard_ctrl.sv
// ---------------------------------------------------------------------------
// leaderboard_ctrl
// Ranks finished stopwatch times into the fast (shortest) and slow (longest)
// top-3 tables, one slot compare per cycle, then shifts the chosen table,
// reports the placement and fires a per-rank buzzer pulse. Also provides a
// registered read port for the display mux.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   handshake for a finished time (ready only in IDLE
//                         with no clear waiting)
//   in_time, in_mode      time value; 01 slow table, 10 fast table, else none
//   clear_req             request to empty both tables (held pending if busy)
//   disp_sel              001..011 fast rank 1..3, 100..110 slow rank 1..3
//   disp_time/disp_valid  selected entry, registered one cycle behind
//   done                  one-cycle pulse when a ranking finishes
//   rank                  0 = not placed, 1..3 placement; held until next done
//   sound                 one-hot buzzer per rank, held SOUND_LEN cycles
//   busy                  sequencer not idle
// ---------------------------------------------------------------------------
module leaderboard_ctrl
    import leaderboard_pkg::*;
#(
    parameter int TIME_W    = TIME_W_DEFAULT,
    parameter int SOUND_LEN = 25_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TIME_W-1:0] in_time,
    input  logic [1:0]        in_mode,
    input  logic              clear_req,
    input  logic [2:0]        disp_sel,
    output logic [TIME_W-1:0] disp_time,
    output logic              disp_valid,
    output logic              done,
    output logic [1:0]        rank,
    output logic [2:0]        sound,
    output logic              busy
);

    localparam int CNT_W = $clog2(SOUND_LEN + 1);

    lb_state_t         r_state;
    logic [TIME_W-1:0] r_time;
    logic [1:0]        r_mode;
    logic [1:0]        r_idx;
    logic [1:0]        r_pos;
    logic              r_placed;
    logic              r_clr_pend;
    logic              r_done;
    logic [1:0]        r_rank;
    logic [2:0]        r_sound;
    logic [CNT_W-1:0]  r_sound_cnt;
    logic [TIME_W-1:0] r_disp_time;
    logic              r_disp_valid;

    logic              w_idle;
    logic              w_clear;
    logic              w_is_fast;
    logic              w_is_slow;
    logic              w_win;
    logic              w_fast_win;
    logic              w_slow_win;
    logic              w_fast_insert;
    logic              w_slow_insert;
    logic              w_sound_load;
    logic [1:0]        w_fast_rd_idx;
    logic [1:0]        w_slow_rd_idx;
    logic [TIME_W-1:0] w_fast_rd_time;
    logic [TIME_W-1:0] w_slow_rd_time;
    logic              w_fast_rd_valid;
    logic              w_slow_rd_valid;

    // A pending clear owns the IDLE cycle it is serviced in, so the
    // handshake is closed for that cycle and the new time waits one more.
    assign w_idle        = (r_state == ST_IDLE);
    assign w_clear       = w_idle && r_clr_pend;
    assign in_ready      = w_idle && !r_clr_pend;
    assign busy          = !w_idle;
    assign w_is_fast     = (r_mode == MODE_FAST);
    assign w_is_slow     = (r_mode == MODE_SLOW);
    assign w_win         = w_is_fast ? w_fast_win : w_slow_win;
    assign w_fast_insert = (r_state == ST_SHIFT) && w_is_fast;
    assign w_slow_insert = (r_state == ST_SHIFT) && w_is_slow;
    assign w_sound_load  = (r_state == ST_DONE) && r_placed;

    // Fast codes are 1-based in the low bits, slow codes are 0-based.
    assign w_fast_rd_idx = disp_sel[1:0] - 2'd1;
    assign w_slow_rd_idx = disp_sel[1:0];

    assign done       = r_done;
    assign rank       = r_rank;
    assign sound      = r_sound;
    assign disp_time  = r_disp_time;
    assign disp_valid = r_disp_valid;

    lb_table #(
        .TIME_W (TIME_W)
    ) u_fast_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_insert   (w_fast_insert),
        .i_pos      (r_pos),
        .i_time     (r_time),
        .i_less     (1'b1),
        .i_cmp_idx  (r_idx),
        .o_win      (w_fast_win),
        .i_rd_idx   (w_fast_rd_idx),
        .o_rd_time  (w_fast_rd_time),
        .o_rd_valid (w_fast_rd_valid)
    );

    lb_table #(
        .TIME_W (TIME_W)
    ) u_slow_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_insert   (w_slow_insert),
        .i_pos      (r_pos),
        .i_time     (r_time),
        .i_less     (1'b0),
        .i_cmp_idx  (r_idx),
        .o_win      (w_slow_win),
        .i_rd_idx   (w_slow_rd_idx),
        .o_rd_time  (w_slow_rd_time),
        .o_rd_valid (w_slow_rd_valid)
    );

    // Clear requests are remembered until the sequencer is idle; any number
    // of pulses before that collapse into a single clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_pend <= 1'b0;
        end else if (w_clear) begin
            r_clr_pend <= 1'b0;
        end else if (clear_req) begin
            r_clr_pend <= 1'b1;
        end
    end

    // Ranking sequencer. CMP walks the target table from slot 0 and stops at
    // the first slot the new time beats; SHIFT performs the insert in the
    // table instance; DONE publishes the placement as a registered pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_time   <= '0;
            r_mode   <= 2'b00;
            r_idx    <= 2'd0;
            r_pos    <= 2'd0;
            r_placed <= 1'b0;
            r_done   <= 1'b0;
            r_rank   <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_clr_pend && in_valid) begin
                        r_time   <= in_time;
                        r_mode   <= in_mode;
                        r_idx    <= 2'd0;
                        r_placed <= 1'b0;
                        r_state  <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (!w_is_fast && !w_is_slow) begin
                        r_state <= ST_DONE;
                    end else if (w_win) begin
                        r_pos    <= r_idx;
                        r_placed <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end else if (r_idx == 2'd2) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                ST_SHIFT: begin
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_rank  <= r_placed ? (r_pos + 2'd1) : 2'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Buzzer pulse. A new placement restarts the pulse even if an older one
    // is still sounding; otherwise the counter runs down and the line drops
    // on the cycle it reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sound     <= 3'b000;
            r_sound_cnt <= '0;
        end else if (w_sound_load) begin
            r_sound     <= rank_onehot(r_pos + 2'd1);
            r_sound_cnt <= CNT_W'(SOUND_LEN);
        end else if (r_sound_cnt != '0) begin
            r_sound_cnt <= r_sound_cnt - 1'b1;
            if (r_sound_cnt == CNT_W'(1)) begin
                r_sound <= 3'b000;
            end
        end
    end

    // Registered display read; follows the select and the tables with one
    // cycle of delay, and unused select codes read back as an empty slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_time  <= '0;
            r_disp_valid <= 1'b0;
        end else begin
            case (disp_sel)
                DISP_FAST1, DISP_FAST2, DISP_FAST3: begin
                    r_disp_time  <= w_fast_rd_time;
                    r_disp_valid <= w_fast_rd_valid;
                end
                DISP_SLOW1, DISP_SLOW2, DISP_SLOW3: begin
                    r_disp_time  <= w_slow_rd_time;
                    r_disp_valid <= w_slow_rd_valid;
                end
                default: begin
                    r_disp_time  <= '0;
                    r_disp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
